// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of a PWM input per period and flags a stalled input.
module pwm_capture #(
    parameter int CNT_W = 10,
    parameter int SYNC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_level
);
    localparam logic [1:0] WAIT = 2'd0, HIGH = 2'd1, LOW = 2'd2;
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    logic [SYNC-1:0] sync_q, sync_d;
    logic prev_q, prev_d;
    logic [1:0] state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d;
    logic [CNT_W-1:0] high_q, high_d, period_q, period_d;
    logic valid_q, valid_d, stuck_q, stuck_d, stuck_level_q, stuck_level_d;
    logic pwm_s, rise, fall, timeout, publish;
    always_comb begin
        pwm_s = sync_q[SYNC-1];
        rise = pwm_s & ~prev_q;
        fall = ~pwm_s & prev_q;
        // a rise always wins over the timeout, so a MAX-length period still publishes
        timeout = (pcnt_q == MAX) & ~rise;
        publish = rise && state_q == LOW;
        sync_d = {sync_q[SYNC-2:0], pwm_in};
        prev_d = pwm_s;
        state_d = rise ? HIGH : timeout ? WAIT : (state_q == HIGH && fall) ? LOW : state_q;
        hcnt_d = rise ? ONE : (state_q == HIGH && !fall && !timeout) ? hcnt_q + ONE : hcnt_q;
        pcnt_d = rise ? ONE : timeout ? MAX : pcnt_q + ONE;
        high_d = publish ? hcnt_q : high_q;
        period_d = publish ? pcnt_q : period_q;
        valid_d = publish;
        stuck_d = rise ? 1'b0 : timeout ? 1'b1 : stuck_q;
        stuck_level_d = (timeout || stuck_q) ? pwm_s : stuck_level_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            state_q <= WAIT;
            hcnt_q <= '0;
            pcnt_q <= '0;
            high_q <= '0;
            period_q <= '0;
            valid_q <= 1'b0;
            stuck_q <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            state_q <= state_d;
            hcnt_q <= hcnt_d;
            pcnt_q <= pcnt_d;
            high_q <= high_d;
            period_q <= period_d;
            valid_q <= valid_d;
            stuck_q <= stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end
    assign high_count = high_q;
    assign period_count = period_q;
    assign valid = valid_q;
    assign stuck = stuck_q;
    assign stuck_level = stuck_level_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized PWM waveforms checked against per-period high/period expectations.
module tb_pwm_capture;
    localparam int CNT_W = 10;
    localparam int SYNC = 2;
    localparam int MAX = (1 << CNT_W) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm_in = 1'b0;
    logic [CNT_W-1:0] high_count, period_count;
    logic valid, stuck, stuck_level;
    int total = 0;
    int bad = 0;
    int cap_h[$];
    int cap_p[$];
    bit stuck_seen;

    pwm_capture #(.CNT_W(CNT_W), .SYNC(SYNC)) dut (
        .clk(clk),
        .rst(rst),
        .pwm_in(pwm_in),
        .high_count(high_count),
        .period_count(period_count),
        .valid(valid),
        .stuck(stuck),
        .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic v);
        pwm_in = v;
        @(posedge clk);
        #1;
        if (valid) begin
            cap_h.push_back(int'(high_count));
            cap_p.push_back(int'(period_count));
        end
        if (stuck) stuck_seen = 1'b1;
    endtask

    task automatic play(input int h, input int l);
        repeat (h) cycle(1'b1);
        repeat (l) cycle(1'b0);
    endtask

    task automatic flush;
        cycle(1'b1);
        repeat (SYNC + 3) cycle(1'b0);
    endtask

    task automatic clear_caps;
        cap_h.delete();
        cap_p.delete();
        stuck_seen = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        pwm_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_caps();
    endtask

    task automatic test_reset;
        do_reset();
        repeat (3) cycle(1'b0);
        play(6, 9);
        play(6, 9);
        cycle(1'b1);
        do_reset();
        total++;
        if (high_count !== '0) begin bad++; $display("FAIL reset_high got=%0d exp=0", high_count); end
        total++;
        if (period_count !== '0) begin bad++; $display("FAIL reset_period got=%0d exp=0", period_count); end
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++;
        if (stuck !== 1'b0) begin bad++; $display("FAIL reset_stuck got=%b exp=0", stuck); end
        total++;
        if (stuck_level !== 1'b0) begin bad++; $display("FAIL reset_stuck_level got=%b exp=0", stuck_level); end
    endtask

    task automatic test_levels;
        int lv[4] = '{64, 0, 254, 0};
        lv[3] = int'($urandom_range(1, 253));
        for (int k = 0; k < 4; k++) begin
            int exp_h;
            exp_h = 0;
            for (int c = 0; c < 256; c++) if (c > lv[k]) exp_h++;
            do_reset();
            for (int p = 0; p < 5; p++)
                for (int c = 0; c < 256; c++) cycle(c > lv[k]);
            repeat (SYNC + 2) cycle(1'b0);
            total++;
            if (cap_h.size() != 4) begin bad++; $display("FAIL level%0d_count got=%0d exp=4", lv[k], cap_h.size()); end
            for (int i = 0; i < cap_h.size(); i++) begin
                total++;
                if (cap_h[i] != exp_h) begin bad++; $display("FAIL level%0d_high[%0d] got=%0d exp=%0d", lv[k], i, cap_h[i], exp_h); end
                total++;
                if (cap_p[i] != 256) begin bad++; $display("FAIL level%0d_period[%0d] got=%0d exp=256", lv[k], i, cap_p[i]); end
            end
            total++;
            if (stuck_seen) begin bad++; $display("FAIL level%0d_stuck got=1 exp=0", lv[k]); end
        end
    endtask

    task automatic test_random_periods;
        int eh[$];
        int el[$];
        do_reset();
        repeat (3) cycle(1'b0);
        for (int i = 0; i < 10; i++) begin
            eh.push_back(int'($urandom_range(1, 60)));
            el.push_back(int'($urandom_range(1, 60)));
            play(eh[i], el[i]);
        end
        flush();
        total++;
        if (cap_h.size() != 10) begin bad++; $display("FAIL rand_count got=%0d exp=10", cap_h.size()); end
        for (int i = 0; i < cap_h.size() && i < 10; i++) begin
            total++;
            if (cap_h[i] != eh[i]) begin bad++; $display("FAIL rand_high[%0d] got=%0d exp=%0d", i, cap_h[i], eh[i]); end
            total++;
            if (cap_p[i] != eh[i] + el[i]) begin bad++; $display("FAIL rand_period[%0d] got=%0d exp=%0d", i, cap_p[i], eh[i] + el[i]); end
        end
        total++;
        if (stuck_seen) begin bad++; $display("FAIL rand_stuck got=1 exp=0"); end
    endtask

    task automatic test_stuck_low;
        int idx;
        idx = -1;
        do_reset();
        for (int i = 0; i < MAX + 6; i++) begin
            cycle(1'b0);
            if (stuck && idx < 0) idx = i;
        end
        total++;
        if (idx != MAX) begin bad++; $display("FAIL stuck_low_time got=%0d exp=%0d", idx, MAX); end
        total++;
        if (stuck_level !== 1'b0) begin bad++; $display("FAIL stuck_low_level got=%b exp=0", stuck_level); end
        total++;
        if (cap_h.size() != 0) begin bad++; $display("FAIL stuck_low_valid got=%0d exp=0", cap_h.size()); end
        idx = -1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1);
            if (!stuck && idx < 0) idx = i;
        end
        total++;
        if (idx != SYNC) begin bad++; $display("FAIL stuck_low_clear got=%0d exp=%0d", idx, SYNC); end
        repeat (10) cycle(1'b0);
        repeat (3) play(10, 10);
        flush();
        total++;
        if (cap_h.size() != 4) begin bad++; $display("FAIL square_count got=%0d exp=4", cap_h.size()); end
        if (cap_h.size() > 0) begin
            total++;
            if (cap_h[0] != 10 || cap_p[0] != 20) begin bad++; $display("FAIL square_first got=%0d/%0d exp=10/20", cap_h[0], cap_p[0]); end
        end
    endtask

    task automatic test_stuck_high;
        int idx;
        idx = -1;
        do_reset();
        repeat (3) cycle(1'b0);
        repeat (4) play(3, 7);
        for (int i = 0; i < SYNC + MAX + 6; i++) begin
            cycle(1'b1);
            if (stuck && idx < 0) idx = i;
        end
        total++;
        if (idx != SYNC + MAX) begin bad++; $display("FAIL stuck_high_time got=%0d exp=%0d", idx, SYNC + MAX); end
        total++;
        if (stuck_level !== 1'b1) begin bad++; $display("FAIL stuck_high_level got=%b exp=1", stuck_level); end
        total++;
        if (high_count !== 3 || period_count !== 10) begin bad++; $display("FAIL stuck_high_hold got=%0d/%0d exp=3/10", high_count, period_count); end
        total++;
        if (cap_h.size() != 4) begin bad++; $display("FAIL stuck_high_count got=%0d exp=4", cap_h.size()); end
        for (int i = 0; i < cap_h.size(); i++) begin
            total++;
            if (cap_h[i] != 3 || cap_p[i] != 10) begin bad++; $display("FAIL stuck_high_pub[%0d] got=%0d/%0d exp=3/10", i, cap_h[i], cap_p[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int eh[3] = '{4, 7, 2};
        int el[3] = '{6, 3, 9};
        do_reset();
        repeat (3) cycle(1'b0);
        play(5, 5);
        play(5, 5);
        repeat (4) cycle(1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pwm_in = 1'b0;
        clear_caps();
        total++;
        if (high_count !== '0 || period_count !== '0 || valid !== 1'b0 || stuck !== 1'b0 || stuck_level !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%0d/%0d/%b/%b/%b exp=0/0/0/0/0", high_count, period_count, valid, stuck, stuck_level);
        end
        repeat (6) cycle(1'b0);
        for (int i = 0; i < 3; i++) play(eh[i], el[i]);
        flush();
        total++;
        if (cap_h.size() != 3) begin bad++; $display("FAIL mid_reset_count got=%0d exp=3", cap_h.size()); end
        for (int i = 0; i < cap_h.size() && i < 3; i++) begin
            total++;
            if (cap_h[i] != eh[i] || cap_p[i] != eh[i] + el[i]) begin
                bad++;
                $display("FAIL mid_reset_pub[%0d] got=%0d/%0d exp=%0d/%0d", i, cap_h[i], cap_p[i], eh[i], eh[i] + el[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        repeat (3) cycle(1'b0);
        repeat (12) play(1, 1);
        flush();
        total++;
        if (cap_h.size() != 12) begin bad++; $display("FAIL min_count got=%0d exp=12", cap_h.size()); end
        for (int i = 0; i < cap_h.size(); i++) begin
            total++;
            if (cap_h[i] != 1 || cap_p[i] != 2) begin bad++; $display("FAIL min_pub[%0d] got=%0d/%0d exp=1/2", i, cap_h[i], cap_p[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_levels();
        test_random_periods();
        test_stuck_low();
        test_stuck_high();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
